// File: rtl/pixel_window_gen.sv
// Streaming 3x3 window generator: two line buffers feed a 3x3 shift window.
// Optional status outputs (frame_done, win_cnt) are built when PIXWIN_STATUS_EN is defined.
module pixel_window_gen #(
  parameter int unsigned IMG_W = 8,
  parameter int unsigned IMG_H = 8,
  parameter int unsigned DW    = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] pix_in,
  input  logic          pix_valid,
  input  logic          pix_sof,
  output logic          pix_ready,
  output logic [DW-1:0] win_p1,
  output logic [DW-1:0] win_p2,
  output logic [DW-1:0] win_p3,
  output logic [DW-1:0] win_p4,
  output logic [DW-1:0] win_p5,
  output logic [DW-1:0] win_p6,
  output logic [DW-1:0] win_p7,
  output logic [DW-1:0] win_p8,
  output logic [DW-1:0] win_p9,
  output logic          win_valid,
  input  logic          win_ready
`ifdef PIXWIN_STATUS_EN
  ,
  output logic          frame_done,
  output logic [15:0]   win_cnt
`endif
);

  localparam int unsigned CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  logic [CW-1:0] col_q, col_d, cur_col;
  logic [RW-1:0] row_q, row_d, cur_row;
  logic          last_col, last_row, emit, accept;

  logic [DW-1:0] lb0_q [IMG_W];
  logic [DW-1:0] lb1_q [IMG_W];
  logic [DW-1:0] lb0_rd, lb1_rd;

  logic [DW-1:0] win_q [9];
  logic [DW-1:0] win_d [9];
  logic          valid_q, valid_d;

  assign pix_ready = !valid_q || win_ready;
  assign accept    = pix_valid && pix_ready;

  // pix_sof overrides the tracked position so a restart lands on (0,0) this cycle.
  assign cur_col  = pix_sof ? '0 : col_q;
  assign cur_row  = pix_sof ? '0 : row_q;
  assign last_col = (cur_col == CW'(IMG_W - 1));
  assign last_row = (cur_row == RW'(IMG_H - 1));
  assign emit     = (cur_row >= RW'(2)) && (cur_col >= CW'(2));

  assign lb0_rd = lb0_q[cur_col];
  assign lb1_rd = lb1_q[cur_col];

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (accept) begin
      if (last_col) begin
        col_d = '0;
        row_d = last_row ? '0 : cur_row + 1'b1;
      end else begin
        col_d = cur_col + 1'b1;
        row_d = cur_row;
      end
    end
  end

  always_comb begin
    win_d   = win_q;
    valid_d = valid_q;
    if (accept) begin
      win_d[0] = win_q[1];
      win_d[1] = win_q[2];
      win_d[2] = lb1_rd;
      win_d[3] = win_q[4];
      win_d[4] = win_q[5];
      win_d[5] = lb0_rd;
      win_d[6] = win_q[7];
      win_d[7] = win_q[8];
      win_d[8] = pix_in;
      valid_d  = emit;
    end else if (win_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q   <= '0;
      row_q   <= '0;
      valid_q <= 1'b0;
      win_q   <= '{default: '0};
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      valid_q <= valid_d;
      win_q   <= win_d;
    end
  end

  // Line buffer RAM is intentionally not reset; read-before-write on the same column.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb1_q[cur_col] <= lb0_q[cur_col];
      lb0_q[cur_col] <= pix_in;
    end
  end

  assign win_valid = valid_q;
  assign win_p1    = win_q[0];
  assign win_p2    = win_q[1];
  assign win_p3    = win_q[2];
  assign win_p4    = win_q[3];
  assign win_p5    = win_q[4];
  assign win_p6    = win_q[5];
  assign win_p7    = win_q[6];
  assign win_p8    = win_q[7];
  assign win_p9    = win_q[8];

`ifdef PIXWIN_STATUS_EN
  logic        fd_q, fd_d;
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    fd_d  = accept && last_col && last_row;
    cnt_d = cnt_q;
    if (valid_q && win_ready && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end
    // A new frame start clears the count even if a window is consumed alongside it.
    if (accept && pix_sof) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fd_q  <= 1'b0;
      cnt_q <= '0;
    end else begin
      fd_q  <= fd_d;
      cnt_q <= cnt_d;
    end
  end

  assign frame_done = fd_q;
  assign win_cnt    = cnt_q;
`endif

endmodule

// File: tb/tb_pixel_window_gen.sv
// Randomised self-checking bench for pixel_window_gen against a per-column history model.
// Status outputs are checked when PIXWIN_STATUS_EN is defined.
module tb_pixel_window_gen;
  localparam int W = 8;
  localparam int H = 8;

  localparam logic [7:0] W_ZERO   [9] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                                          8'h00, 8'h00, 8'h00};
  localparam logic [7:0] W_FIRST  [9] = '{8'h00, 8'h01, 8'h02, 8'h10, 8'h11, 8'h12,
                                          8'h20, 8'h21, 8'h22};
  localparam logic [7:0] W_SECOND [9] = '{8'h01, 8'h02, 8'h03, 8'h11, 8'h12, 8'h13,
                                          8'h21, 8'h22, 8'h23};
  localparam logic [7:0] W_LAST   [9] = '{8'h55, 8'h56, 8'h57, 8'h65, 8'h66, 8'h67,
                                          8'h75, 8'h76, 8'h77};

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] pix_in = '0;
  logic       pix_valid = 1'b0;
  logic       pix_sof = 1'b0;
  logic       win_ready = 1'b1;
  logic       pix_ready, win_valid;
  logic [7:0] win_p1, win_p2, win_p3, win_p4, win_p5, win_p6, win_p7, win_p8, win_p9;
`ifdef PIXWIN_STATUS_EN
  logic        frame_done;
  logic [15:0] win_cnt;
`endif

  pixel_window_gen #(.IMG_W(W), .IMG_H(H), .DW(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pix_in    (pix_in),
    .pix_valid (pix_valid),
    .pix_sof   (pix_sof),
    .pix_ready (pix_ready),
    .win_p1    (win_p1),
    .win_p2    (win_p2),
    .win_p3    (win_p3),
    .win_p4    (win_p4),
    .win_p5    (win_p5),
    .win_p6    (win_p6),
    .win_p7    (win_p7),
    .win_p8    (win_p8),
    .win_p9    (win_p9),
    .win_valid (win_valid),
    .win_ready (win_ready)
`ifdef PIXWIN_STATUS_EN
    ,
    .frame_done(frame_done),
    .win_cnt   (win_cnt)
`endif
  );

  always #5 clk = ~clk;

  logic [7:0] dp [9];
  assign dp[0] = win_p1;
  assign dp[1] = win_p2;
  assign dp[2] = win_p3;
  assign dp[3] = win_p4;
  assign dp[4] = win_p5;
  assign dp[5] = win_p6;
  assign dp[6] = win_p7;
  assign dp[7] = win_p8;
  assign dp[8] = win_p9;

  int n_chk = 0;
  int n_pass = 0;
  int hs_cnt = 0;
  int fd_cnt = 0;
  logic [7:0] first_w [9];
  logic [7:0] last_w [9];
  bit rnd_ready = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic check_win(input string name, input logic [7:0] act [9],
                           input logic [7:0] exp [9]);
    for (int k = 0; k < 9; k++) check($sformatf("%s_p%0d", name, k + 1), 32'(act[k]), 32'(exp[k]));
  endtask

  // Reference model: each column remembers its last three pixels; a window is the last
  // three columns' histories whenever the accepted position is interior.
  logic [7:0] hist [W][3];
  logic       m_valid = 1'b0;
  logic [7:0] m_p [9] = '{default: 8'h00};
  int         m_row = 0;
  int         m_col = 0;
  logic       m_fd = 1'b0;
  int         m_cnt = 0;

  always @(posedge clk or negedge rst_n) begin
    bit acc, hs;
    int r, c, idx;
    if (!rst_n) begin
      m_valid = 1'b0;
      m_row   = 0;
      m_col   = 0;
      m_fd    = 1'b0;
      m_cnt   = 0;
    end else begin
      acc = pix_valid && (!m_valid || win_ready);
      hs  = m_valid && win_ready;
      if (hs && m_cnt < 65535) m_cnt++;
      m_fd = 1'b0;
      if (acc) begin
        if (pix_sof) begin
          m_row = 0;
          m_col = 0;
          m_cnt = 0;
        end
        r = m_row;
        c = m_col;
        hist[c][0] = hist[c][1];
        hist[c][1] = hist[c][2];
        hist[c][2] = pix_in;
        m_valid = (r >= 2) && (c >= 2);
        if (m_valid) begin
          for (int k = 0; k < 3; k++) begin
            m_p[k]     = hist[c - 2 + k][0];
            m_p[3 + k] = hist[c - 2 + k][1];
            m_p[6 + k] = hist[c - 2 + k][2];
          end
        end
        m_fd  = (r == H - 1) && (c == W - 1);
        idx   = (r * W + c + 1) % (W * H);
        m_row = idx / W;
        m_col = idx % W;
      end else if (win_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    check("win_valid", 32'(win_valid), 32'(m_valid));
    check("pix_ready", 32'(pix_ready), 32'(!m_valid || win_ready));
    if (m_valid) begin
      for (int k = 0; k < 9; k++) check($sformatf("win_p%0d", k + 1), 32'(dp[k]), 32'(m_p[k]));
    end
`ifdef PIXWIN_STATUS_EN
    check("frame_done", 32'(frame_done), 32'(m_fd));
    check("win_cnt", 32'(win_cnt), 32'(m_cnt));
    if (frame_done) fd_cnt++;
`endif
    if (win_valid && win_ready) begin
      if (hs_cnt == 0) first_w = dp;
      last_w = dp;
      hs_cnt++;
    end
  end

  always @(posedge clk) begin
    #1;
    if (rnd_ready) win_ready = ($urandom_range(0, 3) != 0);
  end

  task automatic send_pixel(input logic [7:0] v, input logic sof);
    bit done = 1'b0;
    pix_in    = v;
    pix_sof   = sof;
    pix_valid = 1'b1;
    for (int t = 0; t < 200 && !done; t++) begin
      @(negedge clk);
      done = pix_ready;
      @(posedge clk);
      #1;
    end
    check("accept", 32'(done), 32'd1);
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    rnd_ready = 1'b0;
    win_ready = 1'b1;
    idle(4);
  endtask

  task automatic full_frame(input bit rnd);
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        send_pixel(rnd ? 8'($urandom) : 8'(r * 16 + c), (r == 0) && (c == 0));
        if (rnd && $urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
      end
    end
  endtask

  task automatic frame_literals(input string tag);
    check({tag, "_windows"}, 32'(hs_cnt), 32'd36);
    check_win({tag, "_first"}, first_w, W_FIRST);
    check_win({tag, "_last"}, last_w, W_LAST);
`ifdef PIXWIN_STATUS_EN
    check({tag, "_win_cnt"}, 32'(win_cnt), 32'd36);
    check({tag, "_frame_done_pulses"}, 32'(fd_cnt), 32'd1);
`endif
  endtask

  initial begin
    #3 rst_n = 1'b0;
    idle(2);
    check("rst_valid", 32'(win_valid), 32'd0);
    check("rst_ready", 32'(pix_ready), 32'd1);
    check_win("rst", dp, W_ZERO);
    @(negedge clk);
    rst_n = 1'b1;
    idle(3);
    check("idle_valid", 32'(win_valid), 32'd0);
    check("idle_ready", 32'(pix_ready), 32'd1);
    check_win("idle", dp, W_ZERO);

    // Full frame, continuous flow.
    hs_cnt = 0;
    fd_cnt = 0;
    full_frame(1'b0);
    drain();
    frame_literals("frame");

    // Backpressure right after the first window.
    hs_cnt = 0;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        send_pixel(8'(r * 16 + c), (r == 0) && (c == 0));
        if (r == 2 && c == 2) begin
          check("bp_first_valid", 32'(win_valid), 32'd1);
          win_ready = 1'b0;
          repeat (5) begin
            idle(1);
            check("bp_ready_low", 32'(pix_ready), 32'd0);
            check_win("bp_hold", dp, W_FIRST);
          end
          win_ready = 1'b1;
        end
        if (r == 2 && c == 3) check_win("bp_next", dp, W_SECOND);
      end
    end
    drain();
    check("bp_windows", 32'(hs_cnt), 32'd36);

    // Mid-frame restart at (3,4) with random data, gaps and backpressure.
    rnd_ready = 1'b1;
    for (int i = 0; i < 28; i++) begin
      send_pixel(8'($urandom), i == 0);
      if ($urandom_range(0, 3) == 0) idle(1);
    end
    send_pixel(8'($urandom), 1'b1);
    hs_cnt = 0;
    for (int i = 1; i < W * H; i++) begin
      send_pixel(8'($urandom), 1'b0);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
    end
    drain();
    check("restart_windows", 32'(hs_cnt), 32'd36);
`ifdef PIXWIN_STATUS_EN
    check("restart_win_cnt", 32'(win_cnt), 32'd36);
`endif

    // Random full frame.
    rnd_ready = 1'b1;
    hs_cnt = 0;
    full_frame(1'b1);
    drain();
    check("rnd_windows", 32'(hs_cnt), 32'd36);

    // Asynchronous reset while a window is held.
    for (int i = 0; i < 19; i++) send_pixel(8'(i), i == 0);
    win_ready = 1'b0;
    idle(1);
    check("pre_rst_valid", 32'(win_valid), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(win_valid), 32'd0);
    check("async_rst_ready", 32'(pix_ready), 32'd1);
    check_win("async_rst", dp, W_ZERO);
    @(negedge clk);
    rst_n = 1'b1;
    win_ready = 1'b1;
    idle(1);
    hs_cnt = 0;
    fd_cnt = 0;
    full_frame(1'b0);
    drain();
    frame_literals("post_rst");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pixel_window_gen.md
Name: pixel_window_gen

Overview:
- Streaming 3x3 window generator placed directly upstream of the image smoothening stage.
- Accepts 8-bit pixels in raster order, one per handshake.
- Buffers two previous image lines and presents a registered 3x3 neighbourhood on win_p1..win_p9, which map one-to-one onto the smoothening stage's ip1..ip9.
- Only full interior windows are emitted; there is no border padding.

Parameters:
- IMG_W, 8, image width in pixels (>=3).
- IMG_H, 8, image height in lines (>=3).
- DW, 8, pixel width in bits.

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- pix_in  in  DW  input pixel
- pix_valid  in  1  pix_in is valid
- pix_sof  in  1  qualifies pix_in as pixel (0,0) of a new frame
- pix_ready  out  1  block can accept a pixel this cycle
- win_p1..win_p9  out  DW each  window pixels: p1..p3 = row r-2, cols c-2, c-1, c; p4..p6 = row r-1; p7..p9 = row r
- win_valid  out  1  window registers hold a valid window
- win_ready  in  1  downstream consumes the window

Behaviour:
- Reset (rst_n low, asynchronous):
  - win_valid=0, all win_p*=0, pix_ready=1.
  - Column/row counters=0; window shift registers=0.
  - Line buffer RAM contents are not reset.
- Accept rule: accept = pix_valid && pix_ready, where pix_ready = !win_valid || win_ready (single output slot, no bubble under continuous flow).
- Counters col (0..IMG_W-1) and row (0..IMG_H-1) give the position of the accepted pixel.
  - pix_sof on an accepted pixel forces position (0,0), including mid-frame; the partial frame is abandoned.
  - After the accept: col wraps IMG_W-1 -> 0 and increments row; row wraps IMG_H-1 -> 0 at the last pixel of the frame.
  - If a new frame arrives without pix_sof, counters simply continue.
- Line buffers: lb0 holds row r-1 and lb1 holds row r-2, each IMG_W x DW, indexed by col.
  - On accept, read lb0[col] and lb1[col], then write lb1[col] <= lb0[col] and lb0[col] <= pix_in in the same cycle (read-before-write).
- Window shift registers: 3 columns x 3 rows. On accept, shift left and load the new right column {lb1[col], lb0[col], pix_in} into {p3, p6, p9}.
- Window valid: if the accepted pixel has row>=2 and col>=2, win_valid=1 on the next cycle with win_p* holding the window. Latency is 1 clock from accept.
- If there is no accept and win_ready=1, win_valid goes to 0. If win_valid=1 and win_ready=0, win_p* and win_valid hold stable and pix_ready=0.
- Windows per frame: (IMG_W-2)*(IMG_H-2). Windows whose column would span a line wrap are never flagged valid.
- Reset mid-frame drops the pending window; the next accepted pixel is treated as (0,0) unless pix_sof is asserted later.
- Simultaneous accept and downstream consume: the new window replaces the old one. If the new pixel yields no window, win_valid goes to 0.

Optional Feature:
- Macro PIXWIN_STATUS_EN.
- When defined, adds two outputs:
  - frame_done (out, 1): registered 1-cycle pulse the cycle after the pixel at (IMG_H-1, IMG_W-1) is accepted.
  - win_cnt (out, 16): windows emitted since the last pix_sof or reset; increments on each win_valid && win_ready; saturates at 16'hFFFF; reset value 0.
- When undefined, neither port nor its logic exists; all other behaviour is identical.

Test Plan:
- Reset then idle: with rst_n low, win_valid=0, win_p*=0, pix_ready=1; these hold after release with pix_valid=0.
- Full 8x8 frame, pixel value = row*16+col, pix_sof on the first pixel, win_ready=1 continuously:
  - first win_valid occurs 1 cycle after accepting (2,2), with p1..p9 = 00,01,02,10,11,12,20,21,22;
  - exactly 36 valid windows are produced;
  - the last window is 55,56,57,65,66,67,75,76,77.
- Backpressure: hold win_ready=0 for 5 cycles after the first valid window. pix_ready=0, window stays 00..22 and is stable; on release the next window is 01,02,03,11,12,13,21,22,23 with no loss.
- Mid-frame restart: assert pix_sof at pixel (3,4) of frame 1, then stream a full frame. No window is emitted before new position (2,2), and 36 windows follow.
- Async reset during active streaming with win_valid=1: win_valid drops immediately without a clock. The next frame with pix_sof behaves as in the full-frame test.
- With PIXWIN_STATUS_EN: after the full-frame test, win_cnt=36 and frame_done pulses exactly once, 1 cycle after pixel (7,7) is accepted.
